// File: rtl/sdram_copy_pkg.sv
// Shared types and helpers for the SDRAM block copy engine.
package sdram_copy_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/sdram_block_copy_if.sv
// Avalon-MM bus between the copy engine (master) and the SDRAM controller (slave).
interface sdram_block_copy_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 32
);
    logic                  chipselect;
    logic [DATA_W/8-1:0]   byteenable;
    logic [ADDR_W-1:0]     address;
    logic                  read_n;
    logic                  write_n;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W-1:0]     readdata;
    logic                  readdatavalid;
    logic                  waitrequest;

    modport master (
        output chipselect, byteenable, address, read_n, write_n, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  chipselect, byteenable, address, read_n, write_n, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/sdram_copy_fifo.sv
// Read-data buffer: synchronous FIFO with first-word-fall-through head output.
module sdram_copy_fifo
    import sdram_copy_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int PTR_W     = clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [PTR_W:0]    level,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_pop;

    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];
    assign empty  = (level == '0);
    assign full   = (level == (PTR_W+1)'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push);
            rd_ptr <= rd_ptr + PTR_W'(do_pop);
            level  <= level + (PTR_W+1)'(push) - (PTR_W+1)'(do_pop);
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !do_pop));

endmodule

// File: rtl/sdram_block_copy.sv
// Pipelined Avalon-MM block copy / fill master with buffered read data.
module sdram_block_copy
    import sdram_copy_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  word_count,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    sdram_block_copy_if.master bus
);

    localparam int BYTES_PER_WORD       = bytes_per_word(DATA_W);
    localparam int LVL_W                = clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(BYTES_PER_WORD);

    state_t            state, state_next;
    logic              mode_q;
    logic [ADDR_W-1:0] src_q, dst_q, address_q;
    logic [LEN_W-1:0]  count_q, reads_issued;
    logic [DATA_W-1:0] fill_q;
    logic              read_n_q, write_n_q;
    logic [LVL_W-1:0]  outstanding;

    logic [DATA_W-1:0] fifo_head;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_empty, fifo_full;

    logic              rd_acc, wr_acc, push, pop, slot_free, write_ok, read_ok;
    logic [LEN_W-1:0]  reads_nxt, writes_nxt;
    logic [ADDR_W-1:0] src_nxt, dst_nxt;
    logic [LVL_W-1:0]  outstanding_nxt, level_nxt;

    sdram_copy_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (bus.readdata),
        .pop       (pop),
        .head      (fifo_head),
        .level     (fifo_level),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Post-edge view of every counter, so the next command can be chosen
    // on the same edge the current one is accepted.
    always_comb begin
        rd_acc          = !read_n_q && !bus.waitrequest;
        wr_acc          = !write_n_q && !bus.waitrequest;
        push            = bus.readdatavalid && (state == RUN);
        pop             = wr_acc && !mode_q && !fifo_empty;
        slot_free       = (read_n_q && write_n_q) || rd_acc || wr_acc;
        reads_nxt       = reads_issued + LEN_W'(rd_acc);
        writes_nxt      = words_done + LEN_W'(wr_acc);
        src_nxt         = rd_acc ? src_q + STEP : src_q;
        dst_nxt         = wr_acc ? dst_q + STEP : dst_q;
        outstanding_nxt = outstanding + LVL_W'(rd_acc) - LVL_W'(push);
        level_nxt       = fifo_level + LVL_W'(push) - LVL_W'(pop);
        write_ok        = (writes_nxt < count_q) && (mode_q || (level_nxt != '0));
        read_ok         = !mode_q && (reads_nxt < count_q) && !fifo_full &&
                          (({1'b0, outstanding_nxt} + {1'b0, level_nxt}) < (LVL_W+1)'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = (word_count == '0) ? DONE : RUN;
            RUN:  if (writes_nxt == count_q) state_next = DONE;
            DONE: if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Datapath and command presentation; write wins when both are eligible.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= 1'b0;
            src_q        <= '0;
            dst_q        <= '0;
            address_q    <= '0;
            count_q      <= '0;
            fill_q       <= '0;
            reads_issued <= '0;
            words_done   <= '0;
            outstanding  <= '0;
            read_n_q     <= 1'b1;
            write_n_q    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    read_n_q  <= 1'b1;
                    write_n_q <= 1'b1;
                    if (start) begin
                        mode_q       <= mode;
                        src_q        <= src_addr;
                        dst_q        <= dst_addr;
                        count_q      <= word_count;
                        fill_q       <= fill_value;
                        reads_issued <= '0;
                        words_done   <= '0;
                        outstanding  <= '0;
                    end
                end
                RUN: begin
                    src_q        <= src_nxt;
                    dst_q        <= dst_nxt;
                    reads_issued <= reads_nxt;
                    words_done   <= writes_nxt;
                    outstanding  <= outstanding_nxt;
                    if (slot_free) begin
                        if (write_ok) begin
                            write_n_q <= 1'b0;
                            read_n_q  <= 1'b1;
                            address_q <= dst_nxt;
                        end else if (read_ok) begin
                            read_n_q  <= 1'b0;
                            write_n_q <= 1'b1;
                            address_q <= src_nxt;
                        end else begin
                            read_n_q  <= 1'b1;
                            write_n_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    read_n_q  <= 1'b1;
                    write_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.chipselect = 1'b1;
    assign bus.byteenable = '1;
    assign bus.address    = address_q;
    assign bus.read_n     = read_n_q;
    assign bus.write_n    = write_n_q;
    assign bus.writedata  = write_n_q ? '0 : (mode_q ? fill_q : fifo_head);

endmodule

// File: tb/tb_sdram_block_copy.sv
// Self-checking bench: vector table plus reset/zero-length sequences against an SDRAM slave model.
module tb_sdram_block_copy;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 32;
    localparam int LEN_W      = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int RD_LAT     = 3;
    localparam int BPW        = DATA_W / 8;

    typedef struct {
        bit          mode;
        logic [31:0] src;
        logic [31:0] dst;
        int          count;
        logic [15:0] fill;
        int          wait_pct;
        bit          seq_init;
        int          exp_words;
        int          exp_reads;
    } vec_t;

    typedef struct {
        int          due;
        logic [15:0] data;
    } ret_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic [ADDR_W-1:0] src_addr = '0;
    logic [ADDR_W-1:0] dst_addr = '0;
    logic [LEN_W-1:0]  word_count = '0;
    logic [DATA_W-1:0] fill_value = '0;
    logic              busy, done;
    logic [LEN_W-1:0]  words_done;

    sdram_block_copy_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sdram_block_copy #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .word_count (word_count),
        .fill_value (fill_value),
        .busy       (busy),
        .done       (done),
        .words_done (words_done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [logic [31:0]];
    ret_t        ret_q [$];
    logic [31:0] wr_log [$];
    logic [15:0] exp_data [$];
    int          cyc, wait_pct, rd_count, viol, out_now, max_out, strobe_cyc;
    int          last_wr_cyc, done_cyc;
    int          n_checks, n_pass;
    bit          prev_pend, prev_done;
    logic        prev_rd, prev_wr;
    logic [31:0] prev_addr;
    logic [15:0] prev_wd;
    ret_t        ret_new;

    // SDRAM slave model: random stall, fixed read latency, protocol watch.
    initial begin
        bus.waitrequest   = 1'b0;
        bus.readdatavalid = 1'b0;
        bus.readdata      = '0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.waitrequest = ($urandom_range(0, 99) < wait_pct);
            if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                bus.readdatavalid = 1'b1;
                bus.readdata      = ret_q[0].data;
                void'(ret_q.pop_front());
                out_now--;
            end else begin
                bus.readdatavalid = 1'b0;
                bus.readdata      = 16'($urandom);
            end
            if (done && !prev_done) done_cyc = cyc;
            prev_done = done;
            if (reset) begin
                prev_pend = 1'b0;
            end else begin
                if (!bus.read_n || !bus.write_n) strobe_cyc++;
                if (!bus.read_n && !bus.write_n) viol++;
                if (bus.chipselect !== 1'b1 || bus.byteenable !== 2'b11) viol++;
                if (prev_pend && (bus.read_n !== prev_rd || bus.write_n !== prev_wr ||
                                  bus.address !== prev_addr)) viol++;
                if (prev_pend && !prev_wr && bus.writedata !== prev_wd) viol++;
                if (!bus.read_n && !bus.waitrequest) begin
                    rd_count++;
                    ret_new.due  = cyc + RD_LAT;
                    ret_new.data = mem.exists(bus.address) ? mem[bus.address] : 16'hDEAD;
                    ret_q.push_back(ret_new);
                    out_now++;
                    if (out_now > max_out) max_out = out_now;
                end
                if (!bus.write_n && !bus.waitrequest) begin
                    mem[bus.address] = bus.writedata;
                    wr_log.push_back(bus.address);
                    last_wr_cyc = cyc;
                end
                prev_pend = (!bus.read_n || !bus.write_n) && bus.waitrequest;
                prev_rd   = bus.read_n;
                prev_wr   = bus.write_n;
                prev_addr = bus.address;
                prev_wd   = bus.writedata;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    endtask

    task automatic clearLogs();
        wr_log.delete();
        rd_count   = 0;
        viol       = 0;
        max_out    = 0;
        strobe_cyc = 0;
    endtask

    // Reference: write i lands at dst + i*BPW (mod 2^32) carrying source word i or the fill value.
    task automatic applyStimulus(input vec_t v);
        logic [31:0] a;
        logic [15:0] val;
        int n, addr_err, data_err;
        mem.delete();
        exp_data.delete();
        clearLogs();
        for (int i = 0; i < v.count; i++) begin
            a   = v.src + 32'(BPW * i);
            val = v.seq_init ? 16'(i + 1) : 16'($urandom);
            if (!v.mode) mem[a] = val;
            exp_data.push_back(v.mode ? v.fill : val);
        end
        wait_pct = v.wait_pct;
        @(negedge clk);
        #1;
        mode       = v.mode;
        src_addr   = v.src;
        dst_addr   = v.dst;
        word_count = 16'(v.count);
        fill_value = v.fill;
        start      = 1'b1;
        @(negedge clk);
        checkOutput("busy_after_start", busy, 1);
        checkOutput("words_done_cleared", words_done, 0);
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("completion", done, 1);
        checkOutput("busy_in_done", busy, 0);
        checkOutput("words_done", words_done, v.exp_words);
        checkOutput("done_latency_le1", (done_cyc - last_wr_cyc) <= 1, 1);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("done_drop", done, 0);
        addr_err = 0;
        for (int i = 0; i < wr_log.size(); i++)
            if (wr_log[i] !== v.dst + 32'(BPW * i)) addr_err++;
        data_err = 0;
        for (int i = 0; i < v.count; i++) begin
            a = v.dst + 32'(BPW * i);
            if (!mem.exists(a) || mem[a] !== exp_data[i]) data_err++;
        end
        checkOutput("write_count", wr_log.size(), v.exp_words);
        checkOutput("read_count", rd_count, v.exp_reads);
        checkOutput("write_addr_errors", addr_err, 0);
        checkOutput("data_errors", data_err, 0);
        checkOutput("protocol_violations", viol, 0);
        checkOutput("max_outstanding_le_depth", max_out <= FIFO_DEPTH, 1);
    endtask

    function automatic vec_t mkVec(bit m, logic [31:0] s, logic [31:0] d, int c,
                                   logic [15:0] f, int w, bit seq);
        vec_t v;
        v.mode = m; v.src = s; v.dst = d; v.count = c; v.fill = f;
        v.wait_pct = w; v.seq_init = seq;
        v.exp_words = c;
        v.exp_reads = m ? 0 : c;
        return v;
    endfunction

    vec_t vecs [$];
    int   n_wait;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        wait_pct = 0;
        out_now  = 0;

        repeat (2) @(negedge clk);
        checkOutput("reset_read_n", bus.read_n, 1);
        checkOutput("reset_write_n", bus.write_n, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_words_done", words_done, 0);
        checkOutput("reset_address", bus.address, 0);
        checkOutput("reset_writedata", bus.writedata, 0);
        #1 reset = 1'b0;

        vecs.push_back('{mode: 1'b0, src: 32'h10, dst: 32'h100, count: 10, fill: 16'h0,
                         wait_pct: 0, seq_init: 1'b1, exp_words: 10, exp_reads: 10});
        vecs.push_back('{mode: 1'b0, src: 32'h1000 + 32'(2 * $urandom_range(0, 255)),
                         dst: 32'h8000 + 32'(2 * $urandom_range(0, 255)), count: 64,
                         fill: 16'h0, wait_pct: 50, seq_init: 1'b0, exp_words: 64, exp_reads: 64});
        vecs.push_back('{mode: 1'b1, src: 32'h0, dst: 32'h200, count: 5, fill: 16'hBEEF,
                         wait_pct: 0, seq_init: 1'b0, exp_words: 5, exp_reads: 0});
        vecs.push_back('{mode: 1'b0, src: 32'h40, dst: 32'hFFFF_FFFC, count: 4, fill: 16'h0,
                         wait_pct: 0, seq_init: 1'b1, exp_words: 4, exp_reads: 4});
        vecs.push_back('{mode: 1'b1, src: 32'h0, dst: 32'hFFFF_FFFE, count: 3, fill: 16'h5A5A,
                         wait_pct: 30, seq_init: 1'b0, exp_words: 3, exp_reads: 0});
        vecs.push_back('{mode: 1'b0, src: 32'h500, dst: 32'h900, count: 1, fill: 16'h0,
                         wait_pct: 0, seq_init: 1'b0, exp_words: 1, exp_reads: 1});
        for (int r = 0; r < 4; r++)
            vecs.push_back(mkVec(1'($urandom_range(0, 1)),
                                 32'h2000 + 32'(2 * $urandom_range(0, 511)),
                                 32'hA000 + 32'(2 * $urandom_range(0, 511)),
                                 $urandom_range(1, 40), 16'($urandom),
                                 $urandom_range(0, 60), 1'b0));

        foreach (vecs[k]) begin
            $display("[TB] vector %0d: mode=%0d count=%0d wait=%0d%%", k, vecs[k].mode,
                     vecs[k].count, vecs[k].wait_pct);
            applyStimulus(vecs[k]);
        end

        // Zero-length request: straight to DONE, no bus traffic.
        clearLogs();
        wait_pct = 0;
        @(negedge clk);
        #1 mode = 1'b0; word_count = '0; start = 1'b1;
        @(negedge clk);
        checkOutput("zero_done", done, 1);
        checkOutput("zero_busy", busy, 0);
        repeat (3) @(negedge clk);
        checkOutput("zero_done_hold", done, 1);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("zero_idle", done, 0);
        checkOutput("zero_no_strobes", strobe_cyc, 0);

        // Reset in the middle of a copy, with reads still in flight.
        mem.delete();
        for (int i = 0; i < 20; i++) mem[32'h3000 + 32'(BPW * i)] = 16'(16'h7000 + i);
        clearLogs();
        @(negedge clk);
        #1 mode = 1'b0; src_addr = 32'h3000; dst_addr = 32'h6000; word_count = 16'd20;
        start = 1'b1;
        n_wait = 0;
        while (wr_log.size() < 3 && n_wait < 500) begin
            @(negedge clk);
            n_wait++;
        end
        checkOutput("midreset_reached_3_writes", wr_log.size() >= 3, 1);
        #1 reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_read_n", bus.read_n, 1);
        checkOutput("midreset_write_n", bus.write_n, 1);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_done", done, 0);
        checkOutput("midreset_words_done", words_done, 0);
        #1 reset = 1'b0; start = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("midreset_idle_no_strobe", bus.read_n & bus.write_n, 1);
        applyStimulus(mkVec(1'b0, 32'h4000, 32'h4800, 2, 16'h0, 0, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
